// File: rtl/mdu_pkg.sv
// Shared types and encodings for the RV32M multiply sequencer and its multiplier.
package mdu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned MULSEL_W  = 4;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam logic [MULSEL_W-1:0] MULSEL_NONE   = 4'd0;
    localparam logic [MULSEL_W-1:0] MULSEL_MUL    = 4'd1;
    localparam logic [MULSEL_W-1:0] MULSEL_MULH   = 4'd2;
    localparam logic [MULSEL_W-1:0] MULSEL_MULHSU = 4'd3;
    localparam logic [MULSEL_W-1:0] MULSEL_MULHU  = 4'd4;

    localparam logic [FUNCT3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [FUNCT3_W-1:0] F3_DIV    = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_REM    = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_REMU   = 3'b111;

    // Multiplier select for a multiply funct3; divide/remainder codes map to none.
    function automatic logic [MULSEL_W-1:0] mulsel_of(input logic [FUNCT3_W-1:0] f3);
        logic [MULSEL_W-1:0] sel;
        case (f3)
            F3_MUL:    sel = MULSEL_MUL;
            F3_MULH:   sel = MULSEL_MULH;
            F3_MULHSU: sel = MULSEL_MULHSU;
            F3_MULHU:  sel = MULSEL_MULHU;
            default:   sel = MULSEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Execute-stage sequencer: holds multiplier inputs for MUL_LAT cycles, then
// presents the captured result to writeback over a valid/ready handshake.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FUNCT3_W-1:0] req_funct3,
    input  logic [REG_W-1:0]    req_rd,
    input  logic [XLEN-1:0]     req_rs1,
    input  logic [XLEN-1:0]     req_rs2,
    input  logic                flush,
    output logic                stall,
    output logic [MULSEL_W-1:0] mul_sel,
    output logic [XLEN-1:0]     mul_a,
    output logic [XLEN-1:0]     mul_b,
    input  logic [XLEN-1:0]     mul_res,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [REG_W-1:0]    wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_illegal
);

    mdu_state_t          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [MULSEL_W-1:0] mul_sel_d;
    logic [XLEN-1:0]     mul_a_d, mul_b_d, wb_data_d;
    logic [REG_W-1:0]    wb_rd_d;
    logic                wb_illegal_d;

    // State and every output are flops; handshake flags track the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            mul_sel    <= MULSEL_NONE;
            mul_a      <= '0;
            mul_b      <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_illegal <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            req_ready  <= (state_d == IDLE);
            stall      <= (state_d != IDLE);
            mul_sel    <= mul_sel_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
            wb_valid   <= (state_d == DONE);
            wb_rd      <= wb_rd_d;
            wb_data    <= wb_data_d;
            wb_illegal <= wb_illegal_d;
        end
    end

    // Next state and next register values; multiplier inputs are zero unless in WAIT.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        mul_sel_d    = mul_sel;
        mul_a_d      = mul_a;
        mul_b_d      = mul_b;
        wb_rd_d      = wb_rd;
        wb_data_d    = wb_data;
        wb_illegal_d = wb_illegal;

        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    wb_rd_d = req_rd;
                    if (!req_funct3[2]) begin
                        cnt_d     = CNT_W'(MUL_LAT);
                        mul_sel_d = mulsel_of(req_funct3);
                        mul_a_d   = req_rs1;
                        mul_b_d   = req_rs2;
                        state_d   = WAIT;
                    end else begin
                        wb_data_d    = '0;
                        wb_illegal_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (flush) begin
                    cnt_d     = '0;
                    mul_sel_d = MULSEL_NONE;
                    mul_a_d   = '0;
                    mul_b_d   = '0;
                    state_d   = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    wb_data_d    = mul_res;
                    wb_illegal_d = 1'b0;
                    mul_sel_d    = MULSEL_NONE;
                    mul_a_d      = '0;
                    mul_b_d      = '0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                // A handshake coinciding with flush still completes; writeback kills it.
                if (wb_ready || flush) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d     = '0;
                mul_sel_d = MULSEL_NONE;
                mul_a_d   = '0;
                mul_b_d   = '0;
                state_d   = IDLE;
            end
        endcase
    end

endmodule
